// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fetch / load-store arbiter for a single-ported memory.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternating winner on contention).
`default_nettype none

module mem_port_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DATA_RD = 2'd1,
      S_DATA_WR = 2'd2,
      S_FETCH   = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              fetch_win;
   logic              grant_i, grant_d;

`ifdef ARB_ROUND_ROBIN_EN
   // Remembers the owner of the most recent granted cycle, idle cycles skipped.
   logic last_fetch_q, last_fetch_d;

   always_comb begin
      fetch_win    = ~last_fetch_q;
      last_fetch_d = last_fetch_q;
      if (grant_i) begin
         last_fetch_d = 1'b1;
      end else if (grant_d) begin
         last_fetch_d = 1'b0;
      end
   end

   // Reset value of 1 lets data win the first contention.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_fetch_q <= 1'b1;
      end else begin
         last_fetch_q <= last_fetch_d;
      end
   end
`else
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0] starve_q, starve_d;

   always_comb begin
      fetch_win = (starve_q == STARVE_LIM);
      starve_d  = starve_q;
      if (!i_req || grant_i) begin
         starve_d = 4'd0;
      end else if (starve_q != STARVE_LIM) begin
         starve_d = starve_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_q <= 4'd0;
      end else begin
         starve_q <= starve_d;
      end
   end
`endif

   // Grants are qualified by rst so nothing reaches the memory while reset is held.
   assign grant_d = rst & d_req & ~(i_req & fetch_win);
   assign grant_i = rst & i_req & ~grant_d;

   always_comb begin
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      state_d = S_IDLE;
      rdata_d = rdata_q;
      if (grant_d) begin
         m_we    = d_we;
         m_addr  = d_addr;
         m_wdata = d_wdata;
         state_d = d_we ? S_DATA_WR : S_DATA_RD;
         if (!d_we) begin
            rdata_d = m_rdata;
         end
      end else if (grant_i) begin
         m_addr  = i_addr;
         state_d = S_FETCH;
         rdata_d = m_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
      end
   end

   assign i_gnt    = grant_i;
   assign d_gnt    = grant_d;
   assign i_rvalid = (state_q == S_FETCH);
   assign d_rvalid = (state_q == S_DATA_RD);
   assign i_rdata  = rdata_q;
   assign d_rdata  = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench for mem_port_arbiter.
`default_nettype none

module tb_mem_port_arbiter;

   localparam int SMAX = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
   logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_we;
   logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;

   mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int k);
      if (k == 16) return 32'hDEADBEEF;
      return (32'(k) * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   // Memory behind the arbiter: combinational read, write at the rising edge.
   logic [31:0] mem [1024];
   logic [9:0]  m_idx;
   assign m_idx   = 10'(m_addr % 32'd1024);
   assign m_rdata = mem[m_idx];

   initial begin
      for (int k = 0; k < 1024; k++) mem[k] = init_word(k);
      forever begin
         @(posedge clk);
         if (m_we) mem[m_idx] = m_wdata;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          gi, gd, we, rst_chk;
      logic [31:0] addr, wdata;
   } gexp_t;
   typedef struct {
      bit          fetch;
      logic [31:0] data;
      int          due;
   } rexp_t;

   gexp_t gq[$];
   rexp_t rq[$];
   int    checks = 0;
   int    passes = 0;

   // Reference model state
   logic [31:0] ref_mem [1024];
   int          fetch_wait;
   bit          last_fetch;

   // Pending requests (held until granted)
   bit          p_i, p_d, p_dw;
   logic [31:0] p_ia, p_da, p_dd;

   task automatic model_cycle(output bit gi, output bit gd);
      gexp_t e;
      bit    fwin;
      gi = 0; gd = 0;
      e = '{gi: 0, gd: 0, we: 0, rst_chk: 0, addr: 32'h0, wdata: 32'h0};
      if (!rst) begin
         fetch_wait = 0;
         last_fetch = 1;
         e.rst_chk  = 1;
         gq.push_back(e);
         return;
      end
`ifdef ARB_ROUND_ROBIN_EN
      fwin = !last_fetch;
`else
      fwin = (fetch_wait == SMAX);
`endif
      if (i_req && d_req) begin
         gi = fwin; gd = !fwin;
      end else begin
         gi = i_req; gd = d_req;
      end
      e.gi = gi; e.gd = gd;
      if (gd) begin
         e.we = d_we; e.addr = d_addr; e.wdata = d_wdata;
         if (d_we) ref_mem[d_addr % 1024] = d_wdata;
         else rq.push_back('{fetch: 0, data: ref_mem[d_addr % 1024], due: cyc + 1});
      end else if (gi) begin
         e.addr = i_addr;
         rq.push_back('{fetch: 1, data: ref_mem[i_addr % 1024], due: cyc + 1});
      end
      gq.push_back(e);
      if (i_req && !gi) fetch_wait = (fetch_wait < SMAX) ? fetch_wait + 1 : SMAX;
      else fetch_wait = 0;
      if (gi) last_fetch = 1;
      else if (gd) last_fetch = 0;
   endtask

   task automatic one_cycle(input bit rv);
      bit gi, gd;
      @(posedge clk);
      #1;
      rst     = rv;
      i_req   = p_i;
      i_addr  = p_i ? p_ia : 32'h0;
      d_req   = p_d;
      d_we    = p_d ? p_dw : 1'b0;
      d_addr  = p_d ? p_da : 32'h0;
      d_wdata = p_d ? p_dd : 32'h0;
      model_cycle(gi, gd);
      if (gi) p_i = 0;
      if (gd) p_d = 0;
   endtask

   task automatic run_cycles(input int n, input int pi, input int pd, input bit rv);
      for (int k = 0; k < n; k++) begin
         if (!p_i && int'($urandom_range(99)) < pi) begin
            p_i = 1; p_ia = $urandom_range(63);
         end
         if (!p_d && int'($urandom_range(99)) < pd) begin
            p_d = 1; p_dw = $urandom_range(1); p_da = $urandom_range(63); p_dd = $urandom;
         end
         one_cycle(rv);
      end
   endtask

   // Monitor: compares every cycle's memory drive and every read return.
   initial begin
      gexp_t e;
      rexp_t r;
      forever begin
         @(negedge clk);
         if (gq.size() > 0) begin
            e = gq.pop_front();
            checks++;
            if (i_gnt !== e.gi || d_gnt !== e.gd || m_we !== e.we || m_addr !== e.addr ||
                m_wdata !== e.wdata || (e.rst_chk && (i_rdata !== 32'h0 || d_rdata !== 32'h0 ||
                i_rvalid !== 1'b0 || d_rvalid !== 1'b0)))
               $display("FAIL grant cyc=%0d got gi=%b gd=%b we=%b addr=%h wd=%h ird=%h | exp gi=%b gd=%b we=%b addr=%h wd=%h rst=%b",
                        cyc, i_gnt, d_gnt, m_we, m_addr, m_wdata, i_rdata,
                        e.gi, e.gd, e.we, e.addr, e.wdata, e.rst_chk);
            else passes++;
         end
         if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            checks++;
            if (i_rvalid !== r.fetch || d_rvalid !== !r.fetch ||
                (r.fetch ? i_rdata : d_rdata) !== r.data)
               $display("FAIL rdata cyc=%0d got irv=%b drv=%b ird=%h drd=%h | exp fetch=%b data=%h",
                        cyc, i_rvalid, d_rvalid, i_rdata, d_rdata, r.fetch, r.data);
            else passes++;
         end else if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
            checks++;
            $display("FAIL spurious_rvalid cyc=%0d got irv=%b drv=%b exp 0 0", cyc, i_rvalid, d_rvalid);
         end
      end
   end

   initial begin
      for (int k = 0; k < 1024; k++) ref_mem[k] = init_word(k);
      fetch_wait = 0; last_fetch = 1;
      p_i = 0; p_d = 0; p_dw = 0; p_ia = 0; p_da = 0; p_dd = 0;

      // Reset held with both requesting, then first grant goes to data
      p_i = 1; p_ia = 32'h4; p_d = 1; p_dw = 0; p_da = 32'h8; p_dd = 32'h0;
      run_cycles(3, 0, 0, 0);
      run_cycles(4, 0, 0, 1);

      // Single fetch of a known word
      p_i = 1; p_ia = 32'h10;
      run_cycles(2, 0, 0, 1);

      // Store then load of the same address
      p_d = 1; p_dw = 1; p_da = 32'h20; p_dd = 32'h12345678;
      run_cycles(1, 0, 0, 1);
      p_d = 1; p_dw = 0; p_da = 32'h20;
      run_cycles(2, 0, 0, 1);

      // Both sides saturated: exercises the fetch starvation bound
      run_cycles(10, 100, 100, 1);
      run_cycles(4, 0, 0, 1);

      // Reset asserted while a load's rvalid is pending
      p_d = 1; p_dw = 0; p_da = 32'h5;
      run_cycles(1, 0, 0, 1);
      @(negedge clk);
      #1;
      rst = 1'b0;
      rq.delete();
      run_cycles(2, 0, 0, 0);
      run_cycles(2, 0, 0, 1);

      // Random mixed traffic
      run_cycles(400, 60, 60, 1);
      run_cycles(6, 0, 0, 1);

      @(negedge clk);
      #1;
      if (gq.size() != 0 || rq.size() != 0) begin
         checks++;
         $display("FAIL drain got gq=%0d rq=%0d exp 0 0", gq.size(), rq.size());
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

`default_nettype wire
